// File: rtl/dcache_data_array_pkg.sv
// Shared types and width helpers for the D-cache data array.
// FSM state encodings and clog2-based index widths.
package dcache_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_CLEAR  = 2'd0;
  localparam state_t ST_IDLE   = 2'd1;
  localparam state_t ST_REFILL = 2'd2;
  localparam state_t ST_COMMIT = 2'd3;

  // Index width for n entries, never below one bit.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dcache_data_array_if.sv
// Controller-side bus of the D-cache data array.
// Read, store and refill handshakes grouped with modports.
interface dcache_data_array_if #(
  parameter int NUM_WAYS   = 2,
  parameter int NUM_SETS   = 8,
  parameter int LINE_BYTES = 16,
  parameter int BEAT_BYTES = 4
) ();

  localparam int IW = dcache_pkg::addr_w(NUM_SETS);
  localparam int WW = dcache_pkg::addr_w(NUM_WAYS);
  localparam int LW = 8 * LINE_BYTES;
  localparam int BW = 8 * BEAT_BYTES;

  logic                   rd_req;
  logic [IW-1:0]          rd_index;
  logic                   rd_valid;
  logic [NUM_WAYS*LW-1:0] rd_data;
  logic                   st_valid;
  logic                   st_ready;
  logic [WW-1:0]          st_way;
  logic [IW-1:0]          st_index;
  logic [LINE_BYTES-1:0]  st_be;
  logic [LW-1:0]          st_data;
  logic                   refill_start;
  logic [WW-1:0]          refill_way;
  logic [IW-1:0]          refill_index;
  logic                   refill_ready;
  logic                   beat_valid;
  logic [BW-1:0]          beat_data;
  logic                   beat_ready;
  logic                   refill_done;
  logic                   busy;

  modport master (
    output rd_req, rd_index,
    output st_valid, st_way, st_index,
    output st_be, st_data,
    output refill_start, refill_way,
    output refill_index,
    output beat_valid, beat_data,
    input  rd_valid, rd_data, st_ready,
    input  refill_ready, beat_ready,
    input  refill_done, busy
  );

  modport slave (
    input  rd_req, rd_index,
    input  st_valid, st_way, st_index,
    input  st_be, st_data,
    input  refill_start, refill_way,
    input  refill_index,
    input  beat_valid, beat_data,
    output rd_valid, rd_data, st_ready,
    output refill_ready, beat_ready,
    output refill_done, busy
  );

endinterface

// File: rtl/dcache_data_array_byte_merge.sv
// Byte-granular line merge: enabled bytes from new_i,
// the rest from old_i. Used by the write port and read bypass.
module dcache_byte_merge #(
  parameter int LINE_BYTES = 16
) (
  input  logic [8*LINE_BYTES-1:0] old_i,
  input  logic [8*LINE_BYTES-1:0] new_i,
  input  logic [LINE_BYTES-1:0]   be_i,
  output logic [8*LINE_BYTES-1:0] line_o
);

  // Per-byte select between old and new data.
  always_comb begin
    line_o = old_i;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (be_i[b]) line_o[8*b +: 8] = new_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/dcache_data_array.sv
// Multi-way D-cache data array with store port, refill sequencer.
// Optional post-reset sweep: define DCACHE_DATA_CLEAR_EN.
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int NUM_WAYS   = 2,
  parameter int NUM_SETS   = 8,
  parameter int LINE_BYTES = 16,
  parameter int BEAT_BYTES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dcache_data_array_if.slave bus
);

  localparam int IW    = addr_w(NUM_SETS);
  localparam int WW    = addr_w(NUM_WAYS);
  localparam int LW    = 8 * LINE_BYTES;
  localparam int BW    = 8 * BEAT_BYTES;
  localparam int BEATS = LINE_BYTES / BEAT_BYTES;
  localparam int CW    = addr_w(BEATS);

  state_t                 state_q, state_d;
  logic [WW-1:0]          way_q;
  logic [IW-1:0]          idx_q;
  logic [CW-1:0]          cnt_q;
  logic [LW-1:0]          buf_q;
  logic                   rd_valid_q;
  logic [NUM_WAYS*LW-1:0] rd_data_q;
  logic [LW-1:0]          mem_q [NUM_WAYS][NUM_SETS];
`ifdef DCACHE_DATA_CLEAR_EN
  logic [IW-1:0]          clr_q;
`endif

  logic                   st_ready;
  logic                   st_fire;
  logic                   commit;
  logic                   last_beat;
  logic                   wr_en;
  logic [WW-1:0]          wr_way;
  logic [IW-1:0]          wr_idx;
  logic [LINE_BYTES-1:0]  wr_be;
  logic [LW-1:0]          wr_new;
  logic [LW-1:0]          wr_old;
  logic [LW-1:0]          wr_line;

  // Store admission: blocked only where it would race the refill.
  always_comb begin
    unique case (state_q)
      ST_IDLE:   st_ready = 1'b1;
      ST_REFILL: st_ready = !(bus.st_index == idx_q &&
                              bus.st_way == way_q);
      default:   st_ready = 1'b0;
    endcase
  end

  assign st_fire   = bus.st_valid & st_ready;
  assign commit    = (state_q == ST_COMMIT);
  assign last_beat = bus.beat_valid &&
                     cnt_q == CW'(BEATS - 1);

  // Single write port: COMMIT owns it, otherwise stores.
  always_comb begin
    wr_en  = commit | st_fire;
    wr_way = commit ? way_q : bus.st_way;
    wr_idx = commit ? idx_q : bus.st_index;
    wr_be  = commit ? '1 : bus.st_be;
    wr_new = commit ? buf_q : bus.st_data;
  end

  assign wr_old = mem_q[wr_way][wr_idx];

  dcache_byte_merge #(.LINE_BYTES(LINE_BYTES)) u_merge (
    .old_i  (wr_old),
    .new_i  (wr_new),
    .be_i   (wr_be),
    .line_o (wr_line)
  );

  // Next-state logic of the clear/refill sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.refill_start) state_d = ST_REFILL;
      ST_REFILL: if (last_beat) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
`ifdef DCACHE_DATA_CLEAR_EN
      default:   if (clr_q == IW'(NUM_SETS - 1))
                   state_d = ST_IDLE;
`else
      default:   state_d = ST_IDLE;
`endif
    endcase
  end

  // Sequencer registers: state, latched target, beat buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef DCACHE_DATA_CLEAR_EN
      state_q <= ST_CLEAR;
      clr_q   <= '0;
`else
      state_q <= ST_IDLE;
`endif
      way_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
`ifdef DCACHE_DATA_CLEAR_EN
      if (state_q == ST_CLEAR) clr_q <= clr_q + 1'b1;
`endif
      if (state_q == ST_IDLE && bus.refill_start) begin
        way_q <= bus.refill_way;
        idx_q <= bus.refill_index;
      end
      if (state_q == ST_REFILL && bus.beat_valid) begin
        buf_q[cnt_q*BW +: BW] <= bus.beat_data;
        cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
      end
    end
  end

  // Storage: plain RAM, optionally swept one set per cycle.
  always_ff @(posedge clk) begin
`ifdef DCACHE_DATA_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      for (int w = 0; w < NUM_WAYS; w++)
        mem_q[w][clr_q] <= '0;
    end else if (wr_en) begin
      mem_q[wr_way][wr_idx] <= wr_line;
    end
`else
    if (wr_en) mem_q[wr_way][wr_idx] <= wr_line;
`endif
  end

  // Read port with same-cycle write bypass per way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (state_q == ST_CLEAR)
            rd_data_q[w*LW +: LW] <= '0;
          else if (wr_en && wr_idx == bus.rd_index &&
                   wr_way == WW'(w))
            rd_data_q[w*LW +: LW] <= wr_line;
          else
            rd_data_q[w*LW +: LW] <=
              mem_q[w][bus.rd_index];
        end
      end
    end
  end

  assign bus.st_ready     = st_ready;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.refill_ready = (state_q == ST_IDLE);
  assign bus.beat_ready   = (state_q == ST_REFILL);
  assign bus.refill_done  = commit;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dcache_data_array.sv
// Randomized bench for dcache_data_array against a line-level
// model. Honors DCACHE_DATA_CLEAR_EN if defined.
module tb_dcache_data_array;

  localparam int NW = 2;
  localparam int NS = 8;
  localparam int LB = 16;
  localparam int BB = 4;
  localparam int LW = 8 * LB;
  localparam int BW = 8 * BB;
  localparam int NB = LB / BB;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_data_array_if #(
    .NUM_WAYS(NW), .NUM_SETS(NS),
    .LINE_BYTES(LB), .BEAT_BYTES(BB)
  ) bus ();

  dcache_data_array #(
    .NUM_WAYS(NW), .NUM_SETS(NS),
    .LINE_BYTES(LB), .BEAT_BYTES(BB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [LW-1:0]    ref_q [NW][NS];
  logic [NW*LW-1:0] last_rd;
  int               n_tests = 0;
  int               n_fail  = 0;
  int               phase   = 0;
  int               rf_way  = 0;
  int               rf_idx  = 0;
  logic [LW-1:0]    rf_line = '0;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] merge(
    input logic [LW-1:0] old_line,
    input logic [LW-1:0] new_line,
    input logic [LB-1:0] be);
    logic [LW-1:0] r;
    r = old_line;
    for (int b = 0; b < LB; b++)
      if (be[b]) r[8*b +: 8] = new_line[8*b +: 8];
    return r;
  endfunction

  function automatic logic [NW*LW-1:0] set_of(input int s);
    logic [NW*LW-1:0] r;
    for (int w = 0; w < NW; w++) r[w*LW +: LW] = ref_q[w][s];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit sv, input int sw,
                       input int si,
                       input logic [LB-1:0] be,
                       input logic [LW-1:0] sd,
                       input bit rr, input int ri);
    bit               rdy;
    logic [NW*LW-1:0] exp_rd;
    bus.st_valid = sv;
    bus.st_way   = 1'(sw);
    bus.st_index = 3'(si);
    bus.st_be    = be;
    bus.st_data  = sd;
    bus.rd_req   = rr;
    bus.rd_index = 3'(ri);
    #1;
    if (phase == 0) rdy = 1'b1;
    else if (phase == 1) rdy = !(sw == rf_way && si == rf_idx);
    else rdy = 1'b0;
    check("st_ready", 256'(bus.st_ready), 256'(rdy));
    check("busy", 256'(bus.busy), 256'(phase != 0));
    check("refill_ready", 256'(bus.refill_ready),
          256'(phase == 0));
    check("beat_ready", 256'(bus.beat_ready), 256'(phase == 1));
    check("refill_done", 256'(bus.refill_done),
          256'(phase == 2));
    if (phase == 2) ref_q[rf_way][rf_idx] = rf_line;
    if (sv && rdy) ref_q[sw][si] = merge(ref_q[sw][si], sd, be);
    exp_rd = set_of(ri);
    tick();
    check("rd_valid", 256'(bus.rd_valid), 256'(rr));
    if (rr) last_rd = exp_rd;
    check("rd_data", 256'(bus.rd_data), 256'(last_rd));
  endtask

  task automatic rand_cycle();
    int sw, si;
    sw = $urandom_range(0, NW - 1);
    si = $urandom_range(0, NS - 1);
    if (phase != 0 && $urandom_range(0, 2) == 0) begin
      sw = rf_way;
      si = rf_idx;
    end
    cycle($urandom_range(0, 1) == 1, sw, si,
          LB'($urandom), {$urandom, $urandom, $urandom, $urandom},
          $urandom_range(0, 1) == 1, $urandom_range(0, NS - 1));
  endtask

  // gap < 0 picks random gaps; directed alternates the store
  // between the refill target line and its sibling way.
  task automatic refill(input int w, input int s,
                        input logic [NB*BW-1:0] beats,
                        input int gap, input bit directed);
    int n = 0;
    bus.refill_start = 1'b1;
    bus.refill_way   = 1'(w);
    bus.refill_index = 3'(s);
    rand_cycle();
    bus.refill_start = 1'b0;
    phase  = 1;
    rf_way = w;
    rf_idx = s;
    for (int k = 0; k < NB; k++) begin
      int g;
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      for (int j = 0; j <= g; j++) begin
        bus.beat_valid = (j == g);
        bus.beat_data  = beats[k*BW +: BW];
        if (directed) begin
          cycle(1'b1, (n % 2 == 0) ? w : 1 - w, s, '1,
                {4{$urandom}}, 1'b0, 0);
          n++;
        end else begin
          rand_cycle();
        end
      end
    end
    bus.beat_valid = 1'b0;
    phase   = 2;
    rf_line = beats;
    rand_cycle();
    phase = 0;
  endtask

  task automatic wait_clear();
    int cnt = 0;
    while (bus.busy && cnt < 32) begin
      cnt++;
      tick();
    end
    check("clear_cycles", 256'(cnt), 256'(NS));
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < NS; s++) ref_q[w][s] = '0;
    tick();
  endtask

  task automatic reset_checks();
    logic busy_exp;
`ifdef DCACHE_DATA_CLEAR_EN
    busy_exp = 1'b1;
`else
    busy_exp = 1'b0;
`endif
    check("rst rd_valid", 256'(bus.rd_valid), 256'(0));
    check("rst rd_data", 256'(bus.rd_data), 256'(0));
    check("rst refill_done", 256'(bus.refill_done), 256'(0));
    check("rst busy", 256'(bus.busy), 256'(busy_exp));
    check("rst refill_ready", 256'(bus.refill_ready),
          256'(!busy_exp));
    last_rd = '0;
  endtask

  initial begin
    logic [LW-1:0] line;
    rst_n = 1'b0;
    bus.rd_req = 0; bus.rd_index = 0; bus.st_valid = 0;
    bus.st_way = 0; bus.st_index = 0; bus.st_be = 0;
    bus.st_data = 0; bus.refill_start = 0; bus.refill_way = 0;
    bus.refill_index = 0; bus.beat_valid = 0; bus.beat_data = 0;
    repeat (2) tick();
    reset_checks();
    #3 rst_n = 1'b1;
`ifdef DCACHE_DATA_CLEAR_EN
    wait_clear();
`else
    tick();
`endif
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < NS; s++)
        cycle(1'b1, w, s, '1, '0, 1'b0, 0);

    cycle(1'b1, 1, 3, 16'h000F, {16{8'hAA}}, 1'b0, 0);
    cycle(1'b0, 0, 0, '0, '0, 1'b1, 3);
    check("aa way1", 256'(last_rd[LW +: LW]),
          256'({96'h0, 32'hAAAA_AAAA}));
    check("aa way0", 256'(last_rd[0 +: LW]), 256'(0));

    line = {$urandom, $urandom, $urandom, $urandom};
    cycle(1'b1, 0, 5, '1, line, 1'b1, 5);
    check("bypass way0", 256'(last_rd[0 +: LW]), 256'(line));

    refill(1, 2, {32'h44444444, 32'h33333333,
                  32'h22222222, 32'h11111111}, 2, 1'b1);
    cycle(1'b0, 0, 0, '0, '0, 1'b1, 2);
    check("refill way1", 256'(last_rd[LW +: LW]),
          256'(128'h44444444_33333333_22222222_11111111));

    for (int i = 0; i < 200; i++) rand_cycle();
    for (int i = 0; i < 8; i++)
      refill($urandom_range(0, NW - 1), $urandom_range(0, NS - 1),
             {$urandom, $urandom, $urandom, $urandom}, -1, 1'b0);
    for (int i = 0; i < 40; i++) rand_cycle();

    bus.refill_start = 1'b1;
    bus.refill_way   = 1'b1;
    bus.refill_index = 3'd2;
    cycle(1'b0, 0, 0, '0, '0, 1'b0, 0);
    bus.refill_start = 1'b0;
    phase  = 1;
    rf_way = 1;
    rf_idx = 2;
    bus.beat_valid = 1'b1;
    bus.beat_data  = 32'hDEAD_BEEF;
    cycle(1'b0, 0, 0, '0, '0, 1'b0, 0);
    bus.beat_data  = 32'hCAFE_F00D;
    cycle(1'b0, 0, 0, '0, '0, 1'b0, 0);
    rst_n = 1'b0;
    #2;
    phase = 0;
    reset_checks();
    #2 rst_n = 1'b1;
`ifdef DCACHE_DATA_CLEAR_EN
    wait_clear();
`else
    tick();
`endif
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 0, 0, '0, '0, 1'b1, 2);
    bus.beat_valid = 1'b0;
    cycle(1'b0, 0, 0, '0, '0, 1'b1, 2);

`ifdef DCACHE_DATA_CLEAR_EN
    for (int i = 0; i < 40; i++) rand_cycle();
    rst_n = 1'b0;
    #2;
    reset_checks();
    #2 rst_n = 1'b1;
    wait_clear();
    for (int s = 0; s < NS; s++)
      cycle(1'b0, 0, 0, '0, '0, 1'b1, s);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
